fir_queue_seq: RTL and testbench

- Controller for the 1024x16 dual-port sample queue that feeds the low-band FIR.
- Decimates incoming sample strobes and generates write enable and write address.
- Once the queue holds TAPS samples, each accepted write launches one read burst. The burst walks oldest to newest while stepping the coefficient address in lockstep.
- Sits between the sample-rate front end and the RAM/MAC datapath.

---
 rtl/fir_queue_pkg.sv | 17 +
 rtl/fir_queue_seq_if.sv | 55 +++++
 rtl/fir_queue_wctl.sv | 55 +++++
 rtl/fir_queue_seq.sv | 153 +++++++++++++++
 tb/tb_fir_queue_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_queue_pkg.sv
// Shared types and default parameters for the FIR sample-queue controller.
// Imported by the interface, the write-side controller and the top level.
package fir_queue_pkg;

    localparam int AW_DEF    = 10;
    localparam int TAPS_DEF  = 1021;
    localparam int DECIM_DEF = 2;

    typedef logic [AW_DEF-1:0] qaddr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fir_queue_seq_if.sv
// Bus between the sample-rate front end and the queue controller / RAM-MAC datapath.
// FIR_QUEUE_SEQ_STALL_EN adds the mac_stall back-pressure input.
interface fir_queue_seq_if
    import fir_queue_pkg::*;
#(
    parameter int AW = AW_DEF
);

    logic          wrt_smpl;
`ifdef FIR_QUEUE_SEQ_STALL_EN
    logic          mac_stall;
`endif
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [AW-1:0] caddr;
    logic          sequencing;
    logic          rd_vld;
    logic          seq_done;
    logic          full;
    logic          overrun;

    modport master (
`ifdef FIR_QUEUE_SEQ_STALL_EN
        output mac_stall,
`endif
        output wrt_smpl,
        input  we,
        input  waddr,
        input  raddr,
        input  caddr,
        input  sequencing,
        input  rd_vld,
        input  seq_done,
        input  full,
        input  overrun
    );

    modport slave (
`ifdef FIR_QUEUE_SEQ_STALL_EN
        input  mac_stall,
`endif
        input  wrt_smpl,
        output we,
        output waddr,
        output raddr,
        output caddr,
        output sequencing,
        output rd_vld,
        output seq_done,
        output full,
        output overrun
    );

endinterface

// File: rtl/fir_queue_wctl.sv
// Write side of the sample queue: strobe decimation, write pointer, fill count
// and the burst trigger raised by every accepted write once TAPS samples are held.
module fir_queue_wctl
    import fir_queue_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int TAPS  = TAPS_DEF,
    parameter int DECIM = DECIM_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wrt_smpl,
    output logic          accept,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] wptr_new,
    output logic          full,
    output logic          trigger
);

    localparam int            PW         = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [AW-1:0] TAPS_CNT   = AW'(TAPS);
    localparam logic [AW-1:0] TAPS_M1    = AW'(TAPS - 1);

    logic [PW-1:0] phase;
    logic [AW-1:0] cnt;

    // Strobes seen while reset is asserted never reach the RAM.
    assign accept   = wrt_smpl & rst_n & (phase == PHASE_LAST);
    assign wptr_new = wptr + 1'b1;
    assign full     = (cnt == TAPS_CNT);
    assign trigger  = accept & (cnt >= TAPS_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (wrt_smpl) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        end
    end

    // The fill count saturates so that every write after the filling one also triggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            cnt  <= '0;
        end else if (accept) begin
            wptr <= wptr_new;
            if (!full) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_queue_seq.sv
// Queue controller for the low-band FIR: write addressing plus oldest-to-newest read bursts.
// Define FIR_QUEUE_SEQ_STALL_EN to let mac_stall freeze a running burst.
module fir_queue_seq
    import fir_queue_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int TAPS  = TAPS_DEF,
    parameter int DECIM = DECIM_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    fir_queue_seq_if.slave bus
);

    localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
    localparam logic [AW-1:0] LAST_C = AW'(TAPS - 1);

    seq_state_t    state;
    seq_state_t    state_next;
    logic          accept;
    logic          full;
    logic          trigger;
    logic          stall;
    logic          load;
    logic          step;
    logic          sequencing;
    logic          pending;
    logic          overrun;
    logic          rd_vld;
    logic          seq_done;
    logic [AW-1:0] wptr;
    logic [AW-1:0] wptr_new;
    logic [AW-1:0] oldest;
    logic [AW-1:0] raddr;
    logic [AW-1:0] caddr;

    fir_queue_wctl #(
        .AW    (AW),
        .TAPS  (TAPS),
        .DECIM (DECIM)
    ) u_wctl (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrt_smpl (bus.wrt_smpl),
        .accept   (accept),
        .wptr     (wptr),
        .wptr_new (wptr_new),
        .full     (full),
        .trigger  (trigger)
    );

`ifdef FIR_QUEUE_SEQ_STALL_EN
    assign stall = bus.mac_stall;
`else
    assign stall = 1'b0;
`endif

    // Base of the latest TAPS samples, including a write landing this very cycle.
    assign oldest     = (accept ? wptr_new : wptr) - TAPS_A;
    assign sequencing = (state == READ) & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = READ;
                    load       = 1'b1;
                end
            end
            READ: begin
                if (!stall) begin
                    step = 1'b1;
                    if (caddr == LAST_C) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (pending || trigger) begin
                    state_next = READ;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr <= '0;
            caddr <= '0;
        end else if (load) begin
            raddr <= oldest;
            caddr <= '0;
        end else if (step) begin
            raddr <= raddr + 1'b1;
            caddr <= caddr + 1'b1;
        end
    end

    // DONE always consumes a pending request, merging any trigger arriving alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (state == DONE) begin
                pending <= 1'b0;
            end else if ((state == READ) && trigger) begin
                pending <= 1'b1;
            end
            if (trigger && pending) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld   <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            rd_vld   <= sequencing;
            seq_done <= (state == DONE);
        end
    end

    assign bus.we         = accept;
    assign bus.waddr      = wptr;
    assign bus.raddr      = raddr;
    assign bus.caddr      = caddr;
    assign bus.sequencing = sequencing;
    assign bus.rd_vld     = rd_vld;
    assign bus.seq_done   = seq_done;
    assign bus.full       = full;
    assign bus.overrun    = overrun;

endmodule

// File: tb/tb_fir_queue_seq.sv
// Testbench for fir_queue_seq: cycle-time burst model on a DECIM=1 instance plus
// directed checks, and a DECIM=2 instance for the decimation pattern.
module tb_fir_queue_seq;

    localparam int AW    = 3;
    localparam int TAPS  = 4;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    fir_queue_seq_if #(.AW(AW)) bus ();
    fir_queue_seq_if #(.AW(AW)) bus_dec ();

    fir_queue_seq #(.AW(AW), .TAPS(TAPS), .DECIM(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fir_queue_seq #(.AW(AW), .TAPS(TAPS), .DECIM(2)) dut_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_dec)
    );

    always #5 clk = ~clk;

    // Model state: bursts are described by their start cycle and base address.
    int m_wptr     = 0;
    int m_cnt      = 0;
    int m_start    = 0;
    int m_oldest   = 0;
    int m_done_cyc = -10;
    int cyc        = 0;
    bit m_active   = 1'b0;
    bit m_pend     = 1'b0;
    bit m_ovr      = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_wptr     = 0;
        m_cnt      = 0;
        m_start    = 0;
        m_oldest   = 0;
        m_done_cyc = -10;
        cyc        = 0;
        m_active   = 1'b0;
        m_pend     = 1'b0;
        m_ovr      = 1'b0;
    endtask

    task automatic modelStep(input logic ws);
        bit trig;
        bit busy;
        bit is_done;
        int new_ptr;
        trig    = ws && (m_cnt + 1 >= TAPS);
        new_ptr = (m_wptr + (ws ? 1 : 0)) % DEPTH;
        busy    = m_active && (cyc <= m_start + TAPS);
        is_done = m_active && (cyc == m_start + TAPS);
        if (is_done) m_done_cyc = cyc + 1;
        if (trig && busy && m_pend) m_ovr = 1'b1;
        if ((trig && !busy) || (is_done && (m_pend || trig))) begin
            m_active = 1'b1;
            m_start  = cyc + 1;
            m_oldest = (new_ptr - TAPS + DEPTH) % DEPTH;
            m_pend   = 1'b0;
        end else if (trig && busy) begin
            m_pend = 1'b1;
        end
        if (ws) begin
            m_wptr = new_ptr;
            if (m_cnt < TAPS) m_cnt++;
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep(bus.wrt_smpl);
        end
    end

    task automatic compareCycle();
        bit exp_seq;
        bit exp_rdv;
        if (!rst_n) begin
            checkOutput("rst_we", bus.we, 0);
            checkOutput("rst_waddr", bus.waddr, 0);
            checkOutput("rst_raddr", bus.raddr, 0);
            checkOutput("rst_caddr", bus.caddr, 0);
            checkOutput("rst_sequencing", bus.sequencing, 0);
            checkOutput("rst_rd_vld", bus.rd_vld, 0);
            checkOutput("rst_seq_done", bus.seq_done, 0);
            checkOutput("rst_full", bus.full, 0);
            checkOutput("rst_overrun", bus.overrun, 0);
        end else begin
            exp_seq = m_active && (cyc >= m_start) && (cyc < m_start + TAPS);
            exp_rdv = m_active && (cyc > m_start) && (cyc <= m_start + TAPS);
            checkOutput("cyc_we", bus.we, bus.wrt_smpl);
            checkOutput("cyc_waddr", bus.waddr, m_wptr);
            checkOutput("cyc_full", bus.full, (m_cnt == TAPS));
            checkOutput("cyc_overrun", bus.overrun, m_ovr);
            checkOutput("cyc_sequencing", bus.sequencing, exp_seq);
            checkOutput("cyc_rd_vld", bus.rd_vld, exp_rdv);
            checkOutput("cyc_seq_done", bus.seq_done, (cyc == m_done_cyc));
            if (exp_seq) begin
                checkOutput("cyc_raddr", bus.raddr, (m_oldest + cyc - m_start) % DEPTH);
                checkOutput("cyc_caddr", bus.caddr, cyc - m_start);
            end
        end
    endtask

    always @(negedge clk) compareCycle();

    task automatic applyStimulus(input logic ws, input logic ws_dec);
        @(posedge clk);
        #1;
        bus.wrt_smpl     = ws;
        bus_dec.wrt_smpl = ws_dec;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] dec_we    [6];
        logic [31:0] dec_waddr [6];
        dec_we    = '{0, 1, 0, 1, 0, 1};
        dec_waddr = '{0, 0, 1, 1, 2, 2};

        bus.wrt_smpl     = 1'b0;
        bus_dec.wrt_smpl = 1'b0;
`ifdef FIR_QUEUE_SEQ_STALL_EN
        bus.mac_stall     = 1'b0;
        bus_dec.mac_stall = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_full", bus.full, 0);
        checkOutput("reset_sequencing", bus.sequencing, 0);
        #2 rst_n = 1'b1;

        // Decimation on the DECIM=2 instance.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("dec_we", bus_dec.we, dec_we[i]);
            checkOutput("dec_waddr", bus_dec.waddr, dec_waddr[i]);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("dec_waddr_end", bus_dec.waddr, 3);
        checkOutput("dec_no_seq", bus_dec.sequencing, 0);

        // Fill to TAPS and watch the first burst.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("fill_we", bus.we, 1);
            checkOutput("fill_waddr", bus.waddr, i);
            checkOutput("fill_full", bus.full, 0);
            checkOutput("fill_seq", bus.sequencing, 0);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("fill4_waddr", bus.waddr, 3);
        for (int k = 0; k < TAPS; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("burst1_full", bus.full, 1);
            checkOutput("burst1_seq", bus.sequencing, 1);
            checkOutput("burst1_raddr", bus.raddr, k);
            checkOutput("burst1_caddr", bus.caddr, k);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("burst1_done_early", bus.seq_done, 0);
        checkOutput("burst1_rdvld_last", bus.rd_vld, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("burst1_seq_done", bus.seq_done, 1);
        checkOutput("burst1_rdvld_off", bus.rd_vld, 0);
        idle(2);

        // Advance wptr to 6, then cross the wrap point.
        applyStimulus(1'b1, 1'b0);
        idle(7);
        applyStimulus(1'b1, 1'b0);
        idle(7);
        applyStimulus(1'b1, 1'b0);
        checkOutput("wrap_waddr6", bus.waddr, 6);
        for (int k = 0; k < TAPS; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("wrap_raddr_a", bus.raddr, 3 + k);
        end
        idle(3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("wrap_waddr7", bus.waddr, 7);
        for (int k = 0; k < TAPS; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("wrap_raddr_b", bus.raddr, 4 + k);
        end
        checkOutput("wrap_waddr0", bus.waddr, 0);
        idle(3);

        // Overlapping triggers: pending, then overrun.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ovl_overrun0", bus.overrun, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ovl_overrun0b", bus.overrun, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovl_overrun1", bus.overrun, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovl_done_gap", bus.sequencing, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovl_restart_seq", bus.sequencing, 1);
        checkOutput("ovl_restart_raddr", bus.raddr, 7);
        checkOutput("ovl_restart_done", bus.seq_done, 1);
        idle(6);
        checkOutput("ovl_sticky", bus.overrun, 1);

        // Trigger landing in the DONE cycle restarts at once.
        applyStimulus(1'b1, 1'b0);
        idle(4);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("done_trig_seq", bus.sequencing, 1);
        checkOutput("done_trig_raddr", bus.raddr, 1);
        idle(7);

        // Reset in the second cycle of a burst.
        applyStimulus(1'b1, 1'b0);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_sequencing", bus.sequencing, 0);
        checkOutput("arst_raddr", bus.raddr, 0);
        checkOutput("arst_caddr", bus.caddr, 0);
        checkOutput("arst_full", bus.full, 0);
        checkOutput("arst_overrun", bus.overrun, 0);
        checkOutput("arst_waddr", bus.waddr, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("refill_full", bus.full, 0);
        checkOutput("refill_no_seq", bus.sequencing, 0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("refill_seq", bus.sequencing, 1);
        checkOutput("refill_raddr", bus.raddr, 0);
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

endmodule
